// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Run harness for the multicycle RV32I core. It holds the core in reset for a
//   fixed number of cycles after start and then lets it run. While running it
//   counts cycles and retired instructions. A run ends on a nonzero store to the
//   tohost address or on timeout. After that the core is frozen and the register
//   file is streamed out over a valid/ready dump port.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | after reset; core held in reset, waiting for start
//   RESET_HOLD | core held in reset for RESET_CYCLES cycles
//   RUN        | core running; counters live; watching for tohost / timeout
//   DUMP       | core stalled; register file streamed one beat per handshake
//   DONE       | core stalled; results held until the next start
module sim_run_controller #(
    parameter int              XLEN         = 32,
    parameter int              NUM_REGS     = 32,
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 256,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter int              CNT_W        = 32,
    localparam int             IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_retire,
    input  logic             i_mem_wr_en,
    input  logic [XLEN-1:0]  i_mem_wr_addr,
    input  logic [XLEN-1:0]  i_mem_wr_data,
    output logic             o_cpu_reset,
    output logic             o_cpu_stall,
    output logic [IDX_W-1:0] o_rf_rd_addr,
    input  logic [XLEN-1:0]  i_rf_rd_data,
    output logic             o_dump_valid,
    input  logic             i_dump_ready,
    output logic [IDX_W-1:0] o_dump_idx,
    output logic [XLEN-1:0]  o_dump_data,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [XLEN-2:0]  o_fail_code,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instret_count
);

    localparam int               HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_instret_count;
    logic              r_pass;
    logic              r_timeout;
    logic [XLEN-2:0]   r_fail_code;

    logic              w_tohost;
    logic              w_timeout_hit;
    logic              w_start_ok;
    logic              w_beat;
    logic              w_last_beat;

    // A store of zero to tohost is not an end-of-program marker.
    assign w_tohost      = i_mem_wr_en && (i_mem_wr_addr == TOHOST_ADDR) && (i_mem_wr_data != '0);
    // The cycle being counted now is the MAX_CYCLES-th run cycle.
    assign w_timeout_hit = (r_cycle_count == TIMEOUT_AT);
    assign w_start_ok    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_beat        = (r_state == ST_DUMP) && i_dump_ready;
    assign w_last_beat   = w_beat && (r_idx == LAST_IDX);

    assign o_rf_rd_addr    = r_idx;
    assign o_dump_idx      = r_idx;
    assign o_dump_data     = i_rf_rd_data;
    assign o_pass          = r_pass;
    assign o_timeout       = r_timeout;
    assign o_fail_code     = r_fail_code;
    assign o_cycle_count   = r_cycle_count;
    assign o_instret_count = r_instret_count;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        w_state_nxt  = r_state;
        o_cpu_reset  = 1'b0;
        o_cpu_stall  = 1'b0;
        o_dump_valid = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_cpu_reset = 1'b1;
                if (i_start) begin
                    w_state_nxt = ST_RESET_HOLD;
                end
            end
            ST_RESET_HOLD: begin
                o_cpu_reset = 1'b1;
                if (r_hold == '0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tohost || w_timeout_hit) begin
                    w_state_nxt = ST_DUMP;
                end
            end
            ST_DUMP: begin
                o_cpu_stall  = 1'b1;
                o_dump_valid = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_cpu_stall = 1'b1;
                o_done      = 1'b1;
                if (i_start) begin
                    w_state_nxt = ST_RESET_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                o_cpu_reset = 1'b1;
            end
        endcase
    end

    // Hold timer, run counters, result flags and dump index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold          <= '0;
            r_idx           <= '0;
            r_cycle_count   <= '0;
            r_instret_count <= '0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_fail_code     <= '0;
        end else if (w_start_ok) begin
            r_hold          <= HOLD_LOAD;
            r_idx           <= '0;
            r_cycle_count   <= '0;
            r_instret_count <= '0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_fail_code     <= '0;
        end else begin
            case (r_state)
                ST_RESET_HOLD: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + CNT_W'(1);
                    end
                    if (i_retire && (r_instret_count != '1)) begin
                        r_instret_count <= r_instret_count + CNT_W'(1);
                    end
                    // A tohost store in the timeout cycle takes priority.
                    if (w_tohost) begin
                        if (i_mem_wr_data == XLEN'(1)) begin
                            r_pass <= 1'b1;
                        end else begin
                            r_pass      <= 1'b0;
                            r_fail_code <= i_mem_wr_data[XLEN-1:1];
                        end
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (w_last_beat) begin
                        r_idx <= '0;
                    end else if (w_beat) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
